// File: rtl/aemb_xmdu.sv
// aemb_xmdu: iterative multiply/divide unit beside the AEMB execution ALU.
// Define AEMB_XMDU_DIV_EN to build the restoring divider; otherwise IDIV/IDIVU are reserved.
module aemb_xmdu #(
  parameter int DW    = 32,
  parameter int MSTEP = 2
) (
  input  logic          gclk,
  input  logic          grst,
  input  logic          gena,
  input  logic          abort_i,
  input  logic          op_stb_i,
  input  logic [2:0]    op_code_i,
  input  logic [DW-1:0] opa_i,
  input  logic [DW-1:0] opb_i,
  output logic          op_rdy_o,
  output logic          res_stb_o,
  output logic [DW-1:0] res_o,
  output logic          res_dz_o
);

  localparam int CW = $clog2(DW) + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*DW-1:0] acc_q, acc_d;
  logic [DW-1:0]   mcand_q, mcand_d;
  logic            neg_q, neg_d;
  logic            hi_q, hi_d;
  logic [DW-1:0]   res_q, res_d;
  logic            dz_q, dz_d;

  logic accept;
  logic is_mul;
  logic mul_sa;
  logic mul_sb;

  logic [DW+MSTEP-1:0]   mul_part;
  logic [DW+MSTEP-1:0]   mul_sum;
  logic [2*DW+MSTEP-1:0] mul_wide;
  logic [2*DW-1:0]       mul_next;
  logic [2*DW-1:0]       fix_val;

  function automatic logic [DW-1:0] mag(
    input logic [DW-1:0] x,
    input logic          s
  );
    return (s && x[DW-1]) ? -x : x;
  endfunction

  assign op_rdy_o  = (state_q == S_IDLE) | (state_q == S_DONE);
  assign res_stb_o = (state_q == S_DONE);
  assign res_o     = res_q;
  assign res_dz_o  = dz_q;

  assign accept = op_stb_i & op_rdy_o & ~abort_i;
  assign is_mul = ~op_code_i[2];
  assign mul_sa = (op_code_i == 3'd1) | (op_code_i == 3'd2);
  assign mul_sb = (op_code_i == 3'd1);

  // acc holds {partial high, unconsumed multiplier}; both shift right by MSTEP
  assign mul_part = {{MSTEP{1'b0}}, mcand_q} *
                    {{DW{1'b0}}, acc_q[MSTEP-1:0]};
  assign mul_sum  = {{MSTEP{1'b0}}, acc_q[2*DW-1:DW]} + mul_part;
  assign mul_wide = {mul_sum, acc_q[DW-1:0]};
  assign mul_next = mul_wide[2*DW+MSTEP-1:MSTEP];

  assign fix_val = neg_q ? -acc_q : acc_q;

`ifdef AEMB_XMDU_DIV_EN
  logic            div_op;
  logic            div_sgn;
  logic            div_dz;
  logic            div_go;
  logic [DW:0]     div_sh;
  logic [DW:0]     div_diff;
  logic [2*DW-1:0] div_next;

  assign div_op  = (op_code_i == 3'd4) | (op_code_i == 3'd5);
  assign div_sgn = (op_code_i == 3'd4);
  assign div_dz  = div_op & ~|opb_i;
  assign div_go  = div_op & |opb_i;

  // acc holds {remainder, dividend shifting into quotient}
  assign div_sh   = {acc_q[2*DW-1:DW], acc_q[DW-1]};
  assign div_diff = div_sh - {1'b0, mcand_q};
  assign div_next = div_diff[DW]
                  ? {div_sh[DW-1:0], acc_q[DW-2:0], 1'b0}
                  : {div_diff[DW-1:0], acc_q[DW-2:0], 1'b1};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    res_d   = res_q;
    dz_d    = dz_q;

    case (state_q)
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_DIV: begin
`ifdef AEMB_XMDU_DIV_EN
        acc_d = div_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
`else
        state_d = S_IDLE;
`endif
      end
      S_FIX: begin
        res_d   = hi_q ? fix_val[2*DW-1:DW] : fix_val[DW-1:0];
        dz_d    = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      unique case (1'b1)
        is_mul: begin
          mcand_d = mag(opa_i, mul_sa);
          acc_d   = {{DW{1'b0}}, mag(opb_i, mul_sb)};
          neg_d   = (mul_sa & opa_i[DW-1]) ^ (mul_sb & opb_i[DW-1]);
          hi_d    = (op_code_i != 3'd0);
          cnt_d   = CW'(DW / MSTEP);
          state_d = S_MUL;
        end
`ifdef AEMB_XMDU_DIV_EN
        div_dz: begin
          res_d   = '0;
          dz_d    = 1'b1;
          state_d = S_DONE;
        end
        div_go: begin
          mcand_d = mag(opb_i, div_sgn);
          acc_d   = {{DW{1'b0}}, mag(opa_i, div_sgn)};
          neg_d   = div_sgn & (opa_i[DW-1] ^ opb_i[DW-1]);
          hi_d    = 1'b0;
          cnt_d   = CW'(DW);
          state_d = S_DIV;
        end
`endif
        default: begin
          res_d   = '0;
          dz_d    = 1'b0;
          state_d = S_DONE;
        end
      endcase
    end

    // a kill drops the op in flight and any simultaneous request
    if (abort_i) begin
      state_d = S_IDLE;
      res_d   = res_q;
      dz_d    = dz_q;
    end
  end

  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      hi_q    <= 1'b0;
      res_q   <= '0;
      dz_q    <= 1'b0;
    end else if (gena) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
    end
  end

endmodule

// File: tb/tb_aemb_xmdu.sv
// tb_aemb_xmdu: directed scoreboard bench for aemb_xmdu (DW=32, MSTEP=2).
// Divide checks follow AEMB_XMDU_DIV_EN; without it IDIV/IDIVU expect the reserved path.
module tb_aemb_xmdu;

`ifdef AEMB_XMDU_DIV_EN
  localparam bit DIVEN = 1'b1;
`else
  localparam bit DIVEN = 1'b0;
`endif

  typedef struct {
    logic [31:0] res;
    logic        dz;
    int          lat;
  } exp_t;

  logic        gclk;
  logic        grst;
  logic        gena;
  logic        abort_i;
  logic        op_stb_i;
  logic [2:0]  op_code_i;
  logic [31:0] opa_i;
  logic [31:0] opb_i;
  logic        op_rdy_o;
  logic        res_stb_o;
  logic [31:0] res_o;
  logic        res_dz_o;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  aemb_xmdu #(.DW(32), .MSTEP(2)) dut (
    .gclk      (gclk),
    .grst      (grst),
    .gena      (gena),
    .abort_i   (abort_i),
    .op_stb_i  (op_stb_i),
    .op_code_i (op_code_i),
    .opa_i     (opa_i),
    .opb_i     (opb_i),
    .op_rdy_o  (op_rdy_o),
    .res_stb_o (res_stb_o),
    .res_o     (res_o),
    .res_dz_o  (res_dz_o)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    logic [63:0] p;
    logic signed [31:0] q;
    e.res = '0;
    e.dz  = 1'b0;
    e.lat = 1;
    case (op)
      3'd0: begin
        p = {32'h0, a} * {32'h0, b};
        e.res = p[31:0];
        e.lat = 18;
      end
      3'd1: begin
        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        e.res = p[63:32];
        e.lat = 18;
      end
      3'd2: begin
        p = {{32{a[31]}}, a} * {32'h0, b};
        e.res = p[63:32];
        e.lat = 18;
      end
      3'd3: begin
        p = {32'h0, a} * {32'h0, b};
        e.res = p[63:32];
        e.lat = 18;
      end
      3'd4, 3'd5: begin
        if (DIVEN) begin
          if (b == 32'h0) begin
            e.dz = 1'b1;
          end else begin
            e.lat = 34;
            if (op == 3'd5) e.res = a / b;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
              e.res = 32'h8000_0000;
            else begin
              q = $signed(a) / $signed(b);
              e.res = q;
            end
          end
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic start(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    sb.push_back(model(op, a, b));
    op_code_i = op;
    opa_i     = a;
    opb_i     = b;
    op_stb_i  = 1'b1;
  endtask

  task automatic wait_res(input string tag, input int frz_at,
                          input int frz_len);
    exp_t e;
    int   k;
    int   w;
    @(negedge gclk);
    op_stb_i = 1'b0;
    k = 1;
    w = 1;
    while (!res_stb_o && w < 200) begin
      if (k == 2 && sb[0].lat > 2) chk({tag, "_busy"}, op_rdy_o, 0);
      if (k == frz_at) begin
        gena = 1'b0;
        repeat (frz_len) begin
          @(negedge gclk);
          w++;
        end
        gena = 1'b1;
      end
      @(negedge gclk);
      k++;
      w++;
    end
    e = sb.pop_front();
    chk({tag, "_lat"}, w, e.lat + frz_len);
    chk({tag, "_res"}, res_o, e.res);
    chk({tag, "_dz"}, res_dz_o, e.dz);
  endtask

  initial begin
    logic [31:0] prev;
    logic [2:0]  ab_op;
    logic        seen;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    grst = 1'b1;
    gena = 1'b1;
    abort_i = 1'b0;
    op_stb_i = 1'b0;
    op_code_i = '0;
    opa_i = '0;
    opb_i = '0;
    #2 grst = 1'b0;
    repeat (2) @(negedge gclk);
    chk("rst_rdy", op_rdy_o, 1);
    chk("rst_stb", res_stb_o, 0);
    chk("rst_res", res_o, 0);
    chk("rst_dz", res_dz_o, 0);
    grst = 1'b1;

    @(negedge gclk); start(3'd0, 32'hFFFF_FFFF, 32'h2); wait_res("mul", 0, 0);
    @(negedge gclk); start(3'd1, 32'hFFFF_FFFF, 32'h2); wait_res("mulh", 0, 0);
    @(negedge gclk); start(3'd3, 32'hFFFF_FFFF, 32'h2); wait_res("mulhu", 0, 0);
    @(negedge gclk); start(3'd2, 32'hFFFF_FFFF, 32'h2); wait_res("mulhsu", 0, 0);

    @(negedge gclk); start(3'd4, 32'hFFFF_FFF9, 32'h2); wait_res("idiv", 0, 0);
    @(negedge gclk); start(3'd5, 32'hFFFF_FFF9, 32'h2); wait_res("idivu", 0, 0);
    @(negedge gclk); start(3'd4, 32'h1234_5678, 32'h0); wait_res("dz", 0, 0);
    @(negedge gclk); start(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_res("ovf", 0, 0);
    @(negedge gclk); start(3'd6, 32'h5, 32'h7); wait_res("rsv", 0, 0);

    @(negedge gclk); start(3'd0, 32'd3, 32'd5); wait_res("frz", 6, 5);
    start(3'd0, 32'd7, 32'd6); wait_res("b2b", 0, 0);

    // kill an op mid-flight with a competing request
    ab_op = DIVEN ? 3'd4 : 3'd3;
    prev = res_o;
    @(negedge gclk);
    op_code_i = ab_op; opa_i = 32'h7654_3210; opb_i = 32'h3; op_stb_i = 1'b1;
    @(negedge gclk);
    op_stb_i = 1'b0;
    repeat (9) @(negedge gclk);
    abort_i = 1'b1;
    op_stb_i = 1'b1; op_code_i = 3'd0; opa_i = 32'd9; opb_i = 32'd9;
    @(negedge gclk);
    abort_i = 1'b0;
    op_stb_i = 1'b0;
    chk("ab_rdy", op_rdy_o, 1);
    chk("ab_stb", res_stb_o, 0);
    chk("ab_res", res_o, prev);
    seen = 1'b0;
    repeat (40) begin
      @(negedge gclk);
      seen = seen | res_stb_o;
    end
    chk("ab_nostb", seen, 0);
    @(negedge gclk); start(3'd0, 32'd2, 32'd2); wait_res("post_ab", 0, 0);

    for (int i = 0; i < 6; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      @(negedge gclk); start(rop, ra, rb); wait_res("rnd", 0, 0);
    end

    // asynchronous reset between edges while busy
    @(negedge gclk); start(3'd0, 32'd2, 32'd2); wait_res("pre_rst", 0, 0);
    @(negedge gclk);
    op_code_i = ab_op; opa_i = 32'd100; opb_i = 32'd7; op_stb_i = 1'b1;
    @(negedge gclk);
    op_stb_i = 1'b0;
    repeat (5) @(negedge gclk);
    #2 grst = 1'b0;
    #1;
    chk("arst_rdy", op_rdy_o, 1);
    chk("arst_res", res_o, 0);
    chk("arst_stb", res_stb_o, 0);
    @(negedge gclk);
    grst = 1'b1;

    @(negedge gclk); start(3'd4, 32'd10, 32'd2); wait_res("idiv10", 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aemb_xmdu.md
Name: aemb_xmdu

Overview:
- Parametrised, multi-cycle multiply/divide unit for the AEMB execution stage.
- Sits beside the single-cycle ALU and is started by the decoder.
- Stalls the pipeline through op_rdy_o / res_stb_o.
- Generalises the single-cycle 32-bit multiplier to any even width and adds iterative high-word multiply and signed/unsigned divide.
- Supports a pipeline freeze (gena) and abort.

Parameters:
- DW, 32, datapath width; must be even and at least 8.
- MSTEP, 2, multiplier bits retired per iteration; one of 1, 2, 4, 8; must divide DW.

Ports:
- gclk  input  1  clock; all state changes on the rising edge.
- grst  input  1  reset; asynchronous, active-low.
- gena  input  1  pipeline enable; when low, all state is frozen.
- abort_i  input  1  kills the operation in flight (branch skip / interrupt).
- op_stb_i  input  1  start request.
- op_code_i  input  3  operation: 0 MUL, 1 MULH (s×s), 2 MULHSU (s×u), 3 MULHU (u×u), 4 IDIV (signed), 5 IDIVU, 6–7 reserved.
- opa_i  input  DW  multiplicand / dividend.
- opb_i  input  DW  multiplier / divisor.
- op_rdy_o  output  1  unit can accept an operation this cycle.
- res_stb_o  output  1  res_o, res_dz_o are valid.
- res_o  output  DW  result.
- res_dz_o  output  1  divide-by-zero flag for the current result.

Behaviour:
- Reset (grst low, asynchronous):
  - state IDLE; op_rdy_o=1; res_stb_o=0; res_o=0; res_dz_o=0.
  - All internal accumulators cleared.
- gena low: state, counters, operands and outputs all hold. Outputs are combinational from held registers, so res_stb_o stays high if already high. The consumer qualifies it with gena.
- Accept: op_stb_i & op_rdy_o & gena & !abort_i at a rising edge. Operands and op code are latched on that edge.
- op_rdy_o = (state==IDLE) | (state==DONE). Back-to-back accept in DONE is legal; the new op starts and DONE is left.
- States:
  - IDLE
  - MUL: DW/MSTEP enabled cycles. Shift-add of MSTEP bits per cycle into a 2·DW accumulator. Operands are converted to magnitude at accept according to signedness.
  - DIV: DW enabled cycles. Restoring, 1 quotient bit per cycle, on magnitudes.
  - FIX: 1 cycle. Applies sign correction and selects the low or high word.
  - DONE: exactly 1 enabled cycle with res_stb_o=1, then IDLE unless a new op is accepted.
- Latency, counted in enabled cycles from the accept edge to the first cycle with res_stb_o=1:
  - MUL ops: DW/MSTEP+2.
  - DIV ops: DW+2.
- Multiply results:
  - MUL returns product[DW-1:0].
  - MULH, MULHSU, MULHU return product[2DW-1:DW] with the stated signedness.
- Divide results:
  - Quotient truncates toward zero.
  - Remainder is not exported.
- Boundary cases (these bypass MUL/DIV and go to DONE directly; res_stb_o is high 1 cycle after accept):
  - Divisor zero: res_o=0, res_dz_o=1.
  - Reserved op code: res_o=0, res_dz_o=0.
- Signed overflow (IDIV of -2^(DW-1) by -1): res_o=-2^(DW-1), res_dz_o=0, full DIV latency.
- res_dz_o is 0 for all non-zero-divisor results and is updated only in DONE.
- res_o and res_dz_o hold their last value after DONE until the next DONE.
- abort_i & gena at an edge:
  - Forces IDLE from any state; no res_stb_o for the killed op.
  - abort_i wins over a simultaneous op_stb_i, and that op is dropped.
  - res_o is not updated.
- An iteration counter of width clog2(DW)+1 loads at accept and counts down. The last iteration is at counter==1; the next edge enters FIX.

Optional Feature:
- Macro: AEMB_XMDU_DIV_EN.
- Defined: IDIV/IDIVU behave as above, with the divider datapath instantiated.
- Undefined: no divider hardware. Op codes 4/5 take the reserved path: res_o=0, res_dz_o=0, res_stb_o 1 cycle after accept. Multiply behaviour is unchanged.

Test Plan:
1. Multiply, DW=32, MSTEP=2, opa=0xFFFFFFFF, opb=0x00000002. Each result has res_stb_o exactly 18 enabled cycles after accept:
   - MUL -> 0xFFFFFFFE.
   - MULH -> 0xFFFFFFFF.
   - MULHU -> 0x00000001.
   - MULHSU -> 0xFFFFFFFF.
2. Divide (DIV_EN defined), res_stb_o at cycle 34, res_dz_o=0:
   - IDIV opa=0xFFFFFFF9 (-7), opb=2 -> 0xFFFFFFFD.
   - IDIVU same operands -> 0x7FFFFFFC.
3. Divide-by-zero and overflow:
   - IDIV opa=0x12345678, opb=0 -> res_o=0, res_dz_o=1, res_stb_o 1 cycle after accept.
   - Then IDIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, res_dz_o=0.
4. Freeze and back-to-back:
   - MUL 3×5 with gena low for 5 cycles mid-op -> res_o=15 at cycle 18+5.
   - Accept next MUL 7×6 in the DONE cycle -> 42 after a further 18 cycles, no IDLE gap.
5. Abort:
   - Assert abort_i with op_stb_i at iteration 10 of an IDIV -> no res_stb_o, res_o keeps its prior value, op_rdy_o=1 next cycle.
   - Following MUL 2×2 -> 4.
6. Reset and no-divider build:
   - Drop grst mid-DIV, between clock edges -> op_rdy_o=1, res_o=0, res_stb_o=0 immediately.
   - DIV_EN undefined: IDIV 10/2 -> res_o=0 in 1 cycle.
